control_sequencer: RTL and testbench
====================================

# control_sequencer

Microcoded control unit for the 8-bit single-bus machine. It steps a fetch/execute state machine, chooses which of the eight bus drivers owns `bus`, and pulses the register load strobes and PC increment. It sits beside the datapath in `computer`, reads the IR opcode and the ALU flags, and writes the `bus_in` mux select and the load enables.

## Interface
- No parameters. Widths are fixed by the 8-bit bus and the 8 bus sources.
- `clk` input 1: single system clock; all state changes on the rising edge.
- `res` input 1: asynchronous, active-low reset.
- `run` input 1: advance enable. When low, state holds and all strobes are forced inactive.
- `ir_op` input 4: opcode, IR[7:4]. Stable from E0 until the next FETCH1 edge.
- `c_flag`, `z_flag` input 1 each: carry and zero from the flags register.
- `bus_sel` output 3: bus source. 0 ZERO, 1 PC, 2 RAM, 3 IR operand (IR[3:0], zero-extended), 4 A, 5 ALU, 6 B, 7 IN port.
- `ld` output 8: load strobes. Bit 0 MAR, 1 RAM, 2 IR, 3 A, 4 B, 5 OUT, 6 PC, 7 FLAGS.
- `pc_inc` output 1: PC increments at the next edge.
- `alu_sub` output 1: ALU subtracts when high.
- `halted` output 1: high in the HALT state.
- `tstate` output 3: current T-state, for debug. FETCH0=0, FETCH1=1, E0=2, E1=3, E2=4, HALT=7.

## Operation
- States: FETCH0 → FETCH1 → E0 → [E1 → [E2]] → FETCH0. HALT is terminal.
- Outputs are combinational from the state, `ir_op` and the flags. Each strobe takes effect at the next rising edge.
- FETCH0: `bus_sel`=PC, `ld[MAR]`.
- FETCH1: `bus_sel`=RAM, `ld[IR]`, `pc_inc`.
- Opcodes and their execute steps:
  - 0x0 NOP: E0 does nothing, then FETCH0.
  - 0x1 LDA: E0 IR→MAR; E1 RAM→A.
  - 0x2 ADD / 0x3 SUB: E0 IR→MAR; E1 RAM→B; E2 ALU→A with `ld[FLAGS]`. `alu_sub`=1 in E2 for SUB only.
  - 0x4 STA: E0 IR→MAR; E1 A→RAM.
  - 0x5 LDI: E0 IR→A.
  - 0x6 JMP: E0 IR→PC.
  - 0x7 JC: as JMP when `c_flag`=1, otherwise NOP.
  - 0x8 JZ: as JMP when `z_flag`=1, otherwise NOP.
  - 0x9 IN: E0 IN→A.
  - 0xE OUT: E0 A→OUT.
  - 0xF HLT: E0 goes to HALT.
  - 0xA–0xD: treated as NOP.
- The last execute step of every opcode returns to FETCH0. Unused steps are never entered.
- HALT: all strobes are 0 and `bus_sel`=ZERO. The state is left only by reset.
- `run`=0 in any state:
  - The state holds.
  - `ld`=0, `pc_inc`=0, `bus_sel`=ZERO.
  - `alu_sub` follows the decode.
  - On the next edge with `run`=1 the held state executes normally.
- Jump flags are sampled combinationally in E0. A flag change in the same cycle as E0 is honoured.
- At most one bus driver is selected per cycle; this is guaranteed by construction.

## Timing
- Reset (`res`=0, asynchronous):
  - state=FETCH0 immediately; `tstate`=0, `halted`=0.
  - `ld`=0, `pc_inc`=0, `alu_sub`=0, `bus_sel`=ZERO. This masking holds while `res` is low, even though the state is FETCH0.
- The first strobes appear in the first cycle after `res` rises with `run`=1.
- Cycles per instruction:
  - 3: NOP, LDI, JMP, JC, JZ, IN, OUT, undefined opcodes.
  - 4: LDA, STA.
  - 5: ADD, SUB.
  - HLT reaches HALT 3 edges after FETCH0.
- Reset asserted mid-instruction aborts it. No strobe is issued after `res` falls.
- `ir_op` is read only in E0–E2. Its value during FETCH0/FETCH1 is don't-care.

## Structure
- Shared package `richie_pkg`:
  - opcode constants;
  - `bus_sel` source codes;
  - `ld` bit indices;
  - state encoding (3-bit, values as `tstate`).
- Sub-module `ctrl_decode`: combinational microcode. Inputs are state, `ir_op`, flags and `run`; outputs are `bus_sel`, `ld`, `pc_inc`, `alu_sub` and the next state.
- `control_sequencer` holds the state register, async reset and output masking.

## Test plan
- Reset release, `run`=1, `ir_op`=0x1 (LDA): cycles show `bus_sel`=1,2,3,2 with `ld`=0x01,0x04,0x01,0x08; `pc_inc` only in cycle 2; back to `tstate`=0 on cycle 5.
- ADD then SUB (0x2, 0x3): E2 gives `bus_sel`=5, `ld`=0x88; `alu_sub`=0 for ADD and 1 for SUB; 5 cycles each.
- JC with `c_flag`=0 then 1: first gives `ld`=0 in E0; second gives `bus_sel`=3, `ld`=0x40. JZ likewise with `z_flag`.
- `run` dropped during E1 of STA for 4 cycles: `tstate` holds at 3 and `ld`=0. On resume the cycle shows `bus_sel`=4, `ld`=0x02 exactly once.
- HLT (0xF): `halted`=1 and `tstate`=7 after E0. Stays there 20 cycles with all strobes 0 whatever `run` and `ir_op` do. `res` pulse returns to `tstate`=0.
- `res` asserted asynchronously mid-E1 of ADD: outputs go to reset values without waiting for a clock edge, and E2 never occurs.

Source files
------------

// File: rtl/richie_pkg.sv
// Shared definitions for the 8-bit single-bus machine control path.
// Contents: opcode constants, bus source codes, load strobe bit
// indices and the sequencer state encoding (values match tstate).
package richie_pkg;

    // Opcodes (IR[7:4]); 0xA-0xD are unassigned and execute as NOP
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_IN  = 4'h9;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Bus source select codes
    localparam logic [2:0] BUS_ZERO = 3'd0;
    localparam logic [2:0] BUS_PC   = 3'd1;
    localparam logic [2:0] BUS_RAM  = 3'd2;
    localparam logic [2:0] BUS_IR   = 3'd3;
    localparam logic [2:0] BUS_A    = 3'd4;
    localparam logic [2:0] BUS_ALU  = 3'd5;
    localparam logic [2:0] BUS_B    = 3'd6;
    localparam logic [2:0] BUS_IN   = 3'd7;

    // Load strobe bit positions within ld[7:0]
    localparam int unsigned LD_MAR   = 0;
    localparam int unsigned LD_RAM   = 1;
    localparam int unsigned LD_IR    = 2;
    localparam int unsigned LD_A     = 3;
    localparam int unsigned LD_B     = 4;
    localparam int unsigned LD_OUT   = 5;
    localparam int unsigned LD_PC    = 6;
    localparam int unsigned LD_FLAGS = 7;

    // Sequencer states; encoding doubles as the tstate debug value
    typedef enum logic [2:0] {
        ST_FETCH0 = 3'd0,
        ST_FETCH1 = 3'd1,
        ST_E0     = 3'd2,
        ST_E1     = 3'd3,
        ST_E2     = 3'd4,
        ST_HALT   = 3'd7
    } state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational microcode for control_sequencer.
// Ports:
//   state      in  3  current sequencer state
//   ir_op      in  4  opcode (IR[7:4])
//   c_flag     in  1  carry flag
//   z_flag     in  1  zero flag
//   run        in  1  advance enable; low holds state, blanks strobes
//   bus_sel    out 3  bus source select
//   ld         out 8  register load strobes
//   pc_inc     out 1  PC increment strobe
//   alu_sub    out 1  ALU subtract select
//   next_state out 3  state to load at the next edge
module ctrl_decode
    import richie_pkg::*;
(
    input  logic [2:0] state,
    input  logic [3:0] ir_op,
    input  logic       c_flag,
    input  logic       z_flag,
    input  logic       run,
    output logic [2:0] bus_sel,
    output logic [7:0] ld,
    output logic       pc_inc,
    output logic       alu_sub,
    output logic [2:0] next_state
);

    state_e st;
    state_e nxt;
    logic   is_alu_op;
    logic   jump_taken;

    assign st         = state_e'(state);
    assign is_alu_op  = (ir_op == OP_ADD) || (ir_op == OP_SUB);
    assign jump_taken = (ir_op == OP_JMP)
                     || ((ir_op == OP_JC) && c_flag)
                     || ((ir_op == OP_JZ) && z_flag);
    assign next_state = nxt;

    // Next-state logic
    always_comb begin
        nxt = st;
        case (st)
            ST_FETCH0: nxt = ST_FETCH1;
            ST_FETCH1: nxt = ST_E0;
            ST_E0: begin
                if (is_alu_op || ir_op == OP_LDA || ir_op == OP_STA)
                    nxt = ST_E1;
                else if (ir_op == OP_HLT)
                    nxt = ST_HALT;
                else
                    nxt = ST_FETCH0;
            end
            ST_E1:   nxt = is_alu_op ? ST_E2 : ST_FETCH0;
            ST_E2:   nxt = ST_FETCH0;
            ST_HALT: nxt = ST_HALT;
            default: nxt = ST_FETCH0;
        endcase
        if (!run)
            nxt = st;
    end

    // Output logic; alu_sub is left unmasked by run so the ALU result
    // stays stable across a stall in E2
    always_comb begin
        bus_sel = BUS_ZERO;
        ld      = '0;
        pc_inc  = 1'b0;
        alu_sub = 1'b0;
        case (st)
            ST_FETCH0: begin
                bus_sel    = BUS_PC;
                ld[LD_MAR] = 1'b1;
            end
            ST_FETCH1: begin
                bus_sel   = BUS_RAM;
                ld[LD_IR] = 1'b1;
                pc_inc    = 1'b1;
            end
            ST_E0: begin
                if (is_alu_op || ir_op == OP_LDA || ir_op == OP_STA) begin
                    bus_sel    = BUS_IR;
                    ld[LD_MAR] = 1'b1;
                end else if (ir_op == OP_LDI) begin
                    bus_sel  = BUS_IR;
                    ld[LD_A] = 1'b1;
                end else if (jump_taken) begin
                    bus_sel   = BUS_IR;
                    ld[LD_PC] = 1'b1;
                end else if (ir_op == OP_IN) begin
                    bus_sel  = BUS_IN;
                    ld[LD_A] = 1'b1;
                end else if (ir_op == OP_OUT) begin
                    bus_sel    = BUS_A;
                    ld[LD_OUT] = 1'b1;
                end
            end
            ST_E1: begin
                if (ir_op == OP_LDA) begin
                    bus_sel  = BUS_RAM;
                    ld[LD_A] = 1'b1;
                end else if (is_alu_op) begin
                    bus_sel  = BUS_RAM;
                    ld[LD_B] = 1'b1;
                end else if (ir_op == OP_STA) begin
                    bus_sel    = BUS_A;
                    ld[LD_RAM] = 1'b1;
                end
            end
            ST_E2: begin
                if (is_alu_op) begin
                    bus_sel      = BUS_ALU;
                    ld[LD_A]     = 1'b1;
                    ld[LD_FLAGS] = 1'b1;
                    alu_sub      = (ir_op == OP_SUB);
                end
            end
            default: ;
        endcase
        if (!run) begin
            bus_sel = BUS_ZERO;
            ld      = '0;
            pc_inc  = 1'b0;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute control unit for the 8-bit single-bus machine.
// Ports:
//   clk     in  1  system clock, rising edge
//   res     in  1  asynchronous active-low reset
//   run     in  1  advance enable
//   ir_op   in  4  opcode (IR[7:4])
//   c_flag  in  1  carry flag
//   z_flag  in  1  zero flag
//   bus_sel out 3  bus source select
//   ld      out 8  load strobes (MAR,RAM,IR,A,B,OUT,PC,FLAGS)
//   pc_inc  out 1  PC increment strobe
//   alu_sub out 1  ALU subtract select
//   halted  out 1  high in HALT
//   tstate  out 3  current T-state
module control_sequencer
    import richie_pkg::*;
(
    input  logic       clk,
    input  logic       res,
    input  logic       run,
    input  logic [3:0] ir_op,
    input  logic       c_flag,
    input  logic       z_flag,
    output logic [2:0] bus_sel,
    output logic [7:0] ld,
    output logic       pc_inc,
    output logic       alu_sub,
    output logic       halted,
    output logic [2:0] tstate
);

    state_e     state_q;
    logic [2:0] next_state;
    logic [2:0] dec_bus_sel;
    logic [7:0] dec_ld;
    logic       dec_pc_inc;
    logic       dec_alu_sub;

    always_ff @(posedge clk or negedge res) begin
        if (!res)
            state_q <= ST_FETCH0;
        else
            state_q <= state_e'(next_state);
    end

    ctrl_decode u_decode (
        .state      (state_q),
        .ir_op      (ir_op),
        .c_flag     (c_flag),
        .z_flag     (z_flag),
        .run        (run),
        .bus_sel    (dec_bus_sel),
        .ld         (dec_ld),
        .pc_inc     (dec_pc_inc),
        .alu_sub    (dec_alu_sub),
        .next_state (next_state)
    );

    // Reset blanks the strobes combinationally so nothing fires while
    // res is low, even though the state already reads FETCH0
    always_comb begin
        bus_sel = dec_bus_sel;
        ld      = dec_ld;
        pc_inc  = dec_pc_inc;
        alu_sub = dec_alu_sub;
        if (!res) begin
            bus_sel = BUS_ZERO;
            ld      = '0;
            pc_inc  = 1'b0;
            alu_sub = 1'b0;
        end
    end

    assign tstate = state_q;
    assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer. The reference describes
// each instruction as an ordered list of bus transfers (source ->
// destination set); the expected cycle count, T-state and strobes
// all follow from that list.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       run = 1'b0;
    logic [3:0] ir_op = 4'h0;
    logic       c_flag = 1'b0;
    logic       z_flag = 1'b0;
    logic [2:0] bus_sel;
    logic [7:0] ld;
    logic       pc_inc;
    logic       alu_sub;
    logic       halted;
    logic [2:0] tstate;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference state: position within the current instruction
    int unsigned m_pos  = 0;     // 0,1 = fetch cycles; 2+k = execute step k
    bit          m_halt = 1'b0;

    control_sequencer dut (
        .clk     (clk),
        .res     (res),
        .run     (run),
        .ir_op   (ir_op),
        .c_flag  (c_flag),
        .z_flag  (z_flag),
        .bus_sel (bus_sel),
        .ld      (ld),
        .pc_inc  (pc_inc),
        .alu_sub (alu_sub),
        .halted  (halted),
        .tstate  (tstate)
    );

    always #5 clk = ~clk;

    // Bus sources and load destinations as numbered on the machine
    localparam logic [2:0] S_ZERO = 3'd0, S_RAM = 3'd2, S_IR = 3'd3,
                           S_A = 3'd4, S_ALU = 3'd5, S_IN = 3'd7;
    localparam logic [7:0] D_MAR = 8'h01, D_RAM = 8'h02, D_A = 8'h08,
                           D_B = 8'h10, D_OUT = 8'h20, D_PC = 8'h40,
                           D_FLG = 8'h80;

    // Transfer list of an instruction: step k -> (src, dst), is it the
    // final step, does it enter HALT, does the ALU subtract
    function automatic void xfer(input logic [3:0] op, input logic c,
                                 input logic z, input int unsigned k,
                                 output logic [2:0] src, output logic [7:0] dst,
                                 output bit last, output bit hlt, output logic sub);
        logic [2:0] s [3];
        logic [7:0] d [3];
        int unsigned n;
        s = '{S_ZERO, S_ZERO, S_ZERO};
        d = '{8'h00, 8'h00, 8'h00};
        n = 1;
        hlt = 1'b0;
        sub = 1'b0;
        case (op)
            4'h1: begin n = 2; s = '{S_IR, S_RAM, S_ZERO}; d = '{D_MAR, D_A, 8'h00}; end
            4'h2, 4'h3: begin
                n = 3; s = '{S_IR, S_RAM, S_ALU}; d = '{D_MAR, D_B, D_A | D_FLG};
                sub = (op == 4'h3) && (k == 2);
            end
            4'h4: begin n = 2; s = '{S_IR, S_A, S_ZERO}; d = '{D_MAR, D_RAM, 8'h00}; end
            4'h5: begin s[0] = S_IR; d[0] = D_A; end
            4'h6: begin s[0] = S_IR; d[0] = D_PC; end
            4'h7: if (c) begin s[0] = S_IR; d[0] = D_PC; end
            4'h8: if (z) begin s[0] = S_IR; d[0] = D_PC; end
            4'h9: begin s[0] = S_IN; d[0] = D_A; end
            4'hE: begin s[0] = S_A; d[0] = D_OUT; end
            4'hF: hlt = 1'b1;
            default: ;
        endcase
        src  = s[k];
        dst  = d[k];
        last = (k + 1 == n);
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive inputs (called just after a falling edge) and check outputs
    task automatic drive_check(input logic r, input logic [3:0] op,
                               input logic c, input logic z);
        logic [2:0] e_bus, e_ts;
        logic [7:0] e_ld;
        logic       e_pci, e_sub, e_hl;
        bit         last, hlt;
        run = r; ir_op = op; c_flag = c; z_flag = z;
        #1;
        e_bus = S_ZERO; e_ld = 8'h00; e_pci = 1'b0; e_sub = 1'b0;
        e_hl = 1'b0; e_ts = 3'd0;
        if (!res) begin
            // all zeros
        end else if (m_halt) begin
            e_ts = 3'd7; e_hl = 1'b1;
        end else begin
            e_ts = 3'(m_pos);
            if (m_pos == 0) begin
                e_bus = 3'd1; e_ld = D_MAR;
            end else if (m_pos == 1) begin
                e_bus = S_RAM; e_ld = 8'h04; e_pci = 1'b1;
            end else
                xfer(op, c, z, m_pos - 2, e_bus, e_ld, last, hlt, e_sub);
            if (!r) begin
                e_bus = S_ZERO; e_ld = 8'h00; e_pci = 1'b0;
            end
        end
        check("bus_sel", 8'(bus_sel), 8'(e_bus));
        check("ld",      ld,          e_ld);
        check("pc_inc",  8'(pc_inc),  8'(e_pci));
        check("alu_sub", 8'(alu_sub), 8'(e_sub));
        check("tstate",  8'(tstate),  8'(e_ts));
        check("halted",  8'(halted),  8'(e_hl));
    endtask

    task automatic advance();
        logic [2:0] sx;
        logic [7:0] dx;
        logic       ux;
        bit         last, hlt;
        if (!res || !run || m_halt) return;
        if (m_pos < 2) begin
            m_pos++;
            return;
        end
        xfer(ir_op, c_flag, z_flag, m_pos - 2, sx, dx, last, hlt, ux);
        if (hlt) m_halt = 1'b1;
        else if (last) m_pos = 0;
        else m_pos++;
    endtask

    task automatic cyc(input logic r, input logic [3:0] op,
                       input logic c, input logic z);
        drive_check(r, op, c, z);
        @(posedge clk);
        #1 advance();
        @(negedge clk);
    endtask

    // Run a complete instruction with run held high
    task automatic instr(input logic [3:0] op, input logic c, input logic z);
        int unsigned guard = 0;
        cyc(1'b1, 4'(op + 4'h5), 1'b0, 1'b0);   // fetch-time opcode is don't-care
        while (m_pos != 0 && !m_halt && guard < 10) begin
            cyc(1'b1, op, c, z);
            guard++;
        end
        check("instr_done", 8'(m_pos == 0 || m_halt), 8'd1);
    endtask

    task automatic reset_pulse();
        res = 1'b0;
        m_pos = 0; m_halt = 1'b0;
        cyc(1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b1);
        res = 1'b1;
    endtask

    initial begin
        logic [3:0] op_r;
        @(negedge clk);
        reset_pulse();

        // LDA: 1,2,3,2 / 01,04,01,08, back to FETCH0 on cycle 5
        instr(4'h1, 1'b0, 1'b0);
        check("lda_ts5", 8'(tstate), 8'd0);
        instr(4'h2, 1'b1, 1'b0);
        // SUB with a one-cycle stall in E2: alu_sub must stay high
        cyc(1'b1, 4'h0, 1'b0, 1'b0);
        cyc(1'b1, 4'h3, 1'b0, 1'b0);
        cyc(1'b1, 4'h3, 1'b0, 1'b0);
        cyc(1'b1, 4'h3, 1'b0, 1'b0);
        cyc(1'b0, 4'h3, 1'b0, 1'b0);
        cyc(1'b1, 4'h3, 1'b0, 1'b0);
        // conditional jumps, not taken then taken
        instr(4'h7, 1'b0, 1'b1);
        instr(4'h7, 1'b1, 1'b0);
        instr(4'h8, 1'b1, 1'b0);
        instr(4'h8, 1'b0, 1'b1);
        // STA with run dropped for 4 cycles in E1
        cyc(1'b1, 4'h0, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, 1'b0, 1'b0);
        cyc(1'b1, 4'h4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'h4, 1'b0, 1'b0);
        cyc(1'b1, 4'h4, 1'b0, 1'b0);
        check("sta_done", 8'(tstate), 8'd0);

        // randomized instruction stream with random stalls and flags
        op_r = 4'h0;
        for (int i = 0; i < 400; i++) begin
            if (m_pos == 0) op_r = 4'($urandom_range(0, 14));
            cyc(($urandom_range(0, 4) != 0),
                (m_pos < 2) ? 4'($urandom_range(0, 15)) : op_r,
                1'($urandom), 1'($urandom));
        end
        while (m_pos != 0) cyc(1'b1, op_r, 1'b0, 1'b0);

        // asynchronous reset in E1 of ADD: E2 must never appear
        cyc(1'b1, 4'h0, 1'b0, 1'b0);
        cyc(1'b1, 4'h0, 1'b0, 1'b0);
        cyc(1'b1, 4'h2, 1'b0, 1'b0);
        drive_check(1'b1, 4'h2, 1'b0, 1'b0);
        #2 res = 1'b0;
        m_pos = 0;
        drive_check(1'b1, 4'h2, 1'b0, 1'b0);
        @(posedge clk);
        #1 advance();
        @(negedge clk);
        cyc(1'b1, 4'h2, 1'b0, 1'b0);
        res = 1'b1;
        cyc(1'b1, 4'h2, 1'b0, 1'b0);
        check("post_rst_ts", 8'(tstate), 8'd1);

        // HLT then 20 cycles of arbitrary inputs, then reset
        while (m_pos != 0) cyc(1'b1, 4'h0, 1'b0, 1'b0);
        instr(4'hF, 1'b0, 1'b0);
        check("halt_ts", 8'(tstate), 8'd7);
        for (int i = 0; i < 20; i++)
            cyc(1'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
        reset_pulse();
        check("halt_exit", 8'(tstate), 8'd0);
        cyc(1'b1, 4'h0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
